// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode, status and register-index constants
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Instructions whose valE result is architecturally written back.
  function automatic logic writes_e(input logic [3:0] icode);
    return (icode == I_RRMOVQ) || (icode == I_IRMOVQ) || (icode == I_OPQ) ||
           (icode == I_CALL)   || (icode == I_RET)    || (icode == I_PUSHQ) ||
           (icode == I_POPQ);
  endfunction

  function automatic logic writes_m(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 15x64 register file, two write ports (M wins), two combinational reads
module regfile
  import y86_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we_e,
  input  logic [3:0]  i_dst_e,
  input  logic [63:0] i_val_e,
  input  logic        i_we_m,
  input  logic [3:0]  i_dst_m,
  input  logic [63:0] i_val_m,
  input  logic [3:0]  i_src_a,
  input  logic [3:0]  i_src_b,
  output logic [63:0] o_rval_a,
  output logic [63:0] o_rval_b
);

  logic [63:0] r_regs [0:14];

  // M write is issued last so it overrides E when both target one register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= '0;
    end else begin
      if (i_we_e && (i_dst_e != REG_NONE)) r_regs[i_dst_e] <= i_val_e;
      if (i_we_m && (i_dst_m != REG_NONE)) r_regs[i_dst_m] <= i_val_m;
    end
  end

  assign o_rval_a = (i_src_a == REG_NONE) ? 64'd0 : r_regs[i_src_a];
  assign o_rval_b = (i_src_b == REG_NONE) ? 64'd0 : r_regs[i_src_b];

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - Y86-64 write-back stage: enable decode, status, register file
module write_back
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  W_stat,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [1:0]  stat,
  output logic        halted
);

  logic w_aok;
  logic w_we_e;
  logic w_we_m;

  // Any non-AOK status is an exception in flight and must not commit.
  assign w_aok  = (W_stat == S_AOK);
  assign w_we_e = w_aok && (W_dstE != REG_NONE) && writes_e(W_icode);
  assign w_we_m = w_aok && (W_dstM != REG_NONE) && writes_m(W_icode);

  assign stat   = W_stat;
  assign halted = !w_aok;

  regfile u_regfile (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we_e   (w_we_e),
    .i_dst_e  (W_dstE),
    .i_val_e  (W_valE),
    .i_we_m   (w_we_m),
    .i_dst_m  (W_dstM),
    .i_val_m  (W_valM),
    .i_src_a  (d_srcA),
    .i_src_b  (d_srcB),
    .o_rval_a (d_rvalA),
    .o_rval_b (d_rvalB)
  );

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - self-checking bench for the write_back stage
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [1:0]  stat;
  logic        halted;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  longint unsigned model [0:14];

  write_back dut (
    .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned model_rd(input logic [3:0] idx);
    if (idx == 4'hF) return 64'd0;
    return model[idx];
  endfunction

  // Architectural model: what the register file must hold after each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) model[i] = 64'd0;
      started = 1'b1;
    end else if (W_stat == 2'd0) begin
      if (W_dstE != 4'hF && (W_icode inside {4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}))
        model[W_dstE] = W_valE;
      if (W_dstM != 4'hF && (W_icode inside {4'h5, 4'hB}))
        model[W_dstM] = W_valM;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("cmp_rvalA", d_rvalA, model_rd(d_srcA));
      check("cmp_rvalB", d_rvalB, model_rd(d_srcB));
      check("cmp_stat", {62'd0, stat}, {62'd0, W_stat});
      check("cmp_halted", {63'd0, halted}, {63'd0, (W_stat != 2'd0)});
    end
  end

  task automatic idle();
    W_stat = 2'd0; W_icode = 4'h1; W_valE = '0; W_valM = '0;
    W_dstE = 4'hF; W_dstM = 4'hF;
  endtask

  // Entered at posedge+1; presents one W instruction for one edge.
  task automatic wr(input logic [1:0] s, input logic [3:0] ic,
                    input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    W_stat = s; W_icode = ic; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(input logic [3:0] idx, input logic [63:0] exp);
    d_srcA = idx; d_srcB = idx;
    #2;
    check($sformatf("rdA_r%0d", idx), d_rvalA, exp);
    check($sformatf("rdB_r%0d", idx), d_rvalB, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; idle(); d_srcA = 4'hF; d_srcB = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) rd(i[3:0], 64'd0);
    rd(4'hF, 64'd0);

    wr(2'd0, 4'h2, 4'd1, 64'd20, 4'hF, 64'd0);
    wr(2'd0, 4'h3, 4'd2, 64'd25, 4'hF, 64'd0);
    wr(2'd0, 4'h6, 4'd4, 64'd60, 4'hF, 64'd0);
    rd(4'd1, 64'd20);
    rd(4'd2, 64'd25);
    rd(4'd4, 64'd60);

    wr(2'd0, 4'h5, 4'd2, 64'd25, 4'd3, 64'd30);
    wr(2'd0, 4'h5, 4'd2, 64'd99, 4'hF, 64'd0);
    rd(4'd3, 64'd30);
    rd(4'd2, 64'd25);
    wr(2'd0, 4'h4, 4'd7, 64'd123, 4'hF, 64'd0);
    rd(4'd7, 64'd0);

    wr(2'd0, 4'hB, 4'd4, 64'd45, 4'd5, 64'd50);
    rd(4'd4, 64'd45);
    rd(4'd5, 64'd50);
    wr(2'd0, 4'hB, 4'd4, 64'd11, 4'd4, 64'd22);
    rd(4'd4, 64'd22);

    W_stat = 2'd2; W_icode = 4'h6; W_dstE = 4'd1; W_valE = 64'd99;
    #2;
    check("adr_stat", {62'd0, stat}, 64'd2);
    check("adr_halted", {63'd0, halted}, 64'd1);
    @(posedge clk); #1; idle();
    rd(4'd1, 64'd20);
    W_stat = 2'd1; W_icode = 4'h2; W_dstE = 4'd6; W_valE = 64'd5;
    #2;
    check("hlt_stat", {62'd0, stat}, 64'd1);
    check("hlt_halted", {63'd0, halted}, 64'd1);
    @(posedge clk); #1; idle();
    rd(4'd6, 64'd0);

    d_srcA = 4'd1; d_srcB = 4'hF;
    W_stat = 2'd0; W_icode = 4'h2; W_dstE = 4'd1; W_valE = 64'd77;
    #2;
    check("rdw_before", d_rvalA, 64'd20);
    @(posedge clk); #1; idle();
    check("rdw_after", d_rvalA, 64'd77);

    rst = 1'b1;
    W_stat = 2'd0; W_icode = 4'h2; W_dstE = 4'd8; W_valE = 64'd55;
    @(posedge clk); #1;
    rst = 1'b0; idle();
    rd(4'd8, 64'd0);
    rd(4'd1, 64'd0);
    wr(2'd0, 4'h2, 4'd8, 64'd55, 4'hF, 64'd0);
    rd(4'd8, 64'd55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
